rpn_sequencer: RTL and testbench

RPN_SEQUENCER -- requirements
Module: rpn_sequencer

---
 rtl/rpn_sequencer.sv | 162 ++++++++++++++++
 tb/tb_rpn_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_sequencer.sv
// RPN token sequencer: turns NUM/ADD/SUB/MUL tokens into PUSH/POP commands on an external stack.
// Define RPN_MUL_EN to build the multiplier; without it a MUL token is rejected into the sticky error state.
module rpn_sequencer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tok_valid,
  input  logic [1:0]   tok_op,
  input  logic [W-1:0] tok_num,
  output logic         tok_ready,
  output logic [W-1:0] stk_in,
  output logic [3:0]   stk_op,
  output logic         stk_apply,
  input  logic [W-1:0] stk_head,
  input  logic         stk_empty,
  input  logic         stk_valid,
  output logic [W-1:0] result,
  output logic         result_valid,
  output logic         err
);

  typedef enum logic [3:0] {
    IDLE, PUSH, WAIT_P, POP_A, WAIT_A, POP_B, WAIT_B, CALC, ERR
  } state_t;

  localparam logic [1:0] OP_NUM   = 2'd0;
  localparam logic [1:0] OP_ADD   = 2'd1;
  localparam logic [1:0] OP_SUB   = 2'd2;
  localparam logic [1:0] OP_MUL   = 2'd3;
  localparam logic [3:0] CMD_PUSH = 4'd0;
  localparam logic [3:0] CMD_POP  = 4'd1;

  state_t       state;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         is_op;

  // deeper is the operand popped second (B), top is the operand popped first (A)
  function automatic logic [W-1:0] calc(input logic [1:0] o, input logic [W-1:0] deeper,
                                        input logic [W-1:0] top);
    case (o)
      OP_ADD:  return deeper + top;
      OP_SUB:  return deeper - top;
`ifdef RPN_MUL_EN
      OP_MUL:  return deeper * top;
`endif
      default: return '0;
    endcase
  endfunction

  // Every stack command is raised on the edge that enters PUSH/POP_A/POP_B/CALC,
  // so stk_apply is high exactly while the FSM sits in one of those states.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      tok_ready    <= 1'b0;
      stk_apply    <= 1'b0;
      stk_op       <= CMD_PUSH;
      stk_in       <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
      op           <= OP_NUM;
      a            <= '0;
      b            <= '0;
      is_op        <= 1'b0;
    end else begin
      stk_apply    <= 1'b0;
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          tok_ready <= !err;
          if (tok_valid && tok_ready) begin
            tok_ready <= 1'b0;
            op        <= tok_op;
            if (tok_op == OP_NUM) begin
              state     <= PUSH;
              stk_apply <= 1'b1;
              stk_op    <= CMD_PUSH;
              stk_in    <= tok_num;
              is_op     <= 1'b0;
            end
`ifndef RPN_MUL_EN
            else if (tok_op == OP_MUL) begin
              state <= ERR;
              err   <= 1'b1;
            end
`endif
            else begin
              state     <= POP_A;
              stk_apply <= 1'b1;
              stk_op    <= CMD_POP;
              is_op     <= 1'b1;
            end
          end
        end
        PUSH: state <= WAIT_P;
        WAIT_P: begin
          if (!stk_valid) begin
            state <= ERR;
            err   <= 1'b1;
          end else begin
            state     <= IDLE;
            tok_ready <= 1'b1;
            if (is_op) begin
              result       <= stk_in;
              result_valid <= 1'b1;
            end
          end
        end
        POP_A: begin
          if (stk_empty) begin
            state <= ERR;
            err   <= 1'b1;
          end else begin
            a     <= stk_head;
            state <= WAIT_A;
          end
        end
        WAIT_A: begin
          if (!stk_valid) begin
            state <= ERR;
            err   <= 1'b1;
          end else begin
            state     <= POP_B;
            stk_apply <= 1'b1;
            stk_op    <= CMD_POP;
          end
        end
        POP_B: begin
          if (stk_empty) begin
            state <= ERR;
            err   <= 1'b1;
          end else begin
            b     <= stk_head;
            state <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (!stk_valid) begin
            state <= ERR;
            err   <= 1'b1;
          end else begin
            state     <= CALC;
            stk_apply <= 1'b1;
            stk_op    <= CMD_PUSH;
            stk_in    <= calc(op, b, a);
          end
        end
        CALC: state <= WAIT_P;
        ERR: begin
          err       <= 1'b1;
          tok_ready <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_sequencer.sv
// Testbench for rpn_sequencer: a 4-deep stack model plus a queue-based RPN reference model.
// Honours RPN_MUL_EN the same way as the design.
module tb_rpn_sequencer;

  localparam int W = 8;
  localparam int Depth = 4;
`ifdef RPN_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         tok_valid;
  logic [1:0]   tok_op;
  logic [W-1:0] tok_num;
  logic         tok_ready;
  logic [W-1:0] stk_in;
  logic [3:0]   stk_op;
  logic         stk_apply;
  logic [W-1:0] stk_head;
  logic         stk_empty;
  logic         stk_valid;
  logic [W-1:0] result;
  logic         result_valid;
  logic         err;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] stkMem [Depth];
  int stkCount;
  int applyCount;
  int pushCount;
  int backToBack;
  logic prevApply;

  int model [$];

  rpn_sequencer #(.W(W)) dut (
    .clk(clk), .rst(rst), .tok_valid(tok_valid), .tok_op(tok_op), .tok_num(tok_num),
    .tok_ready(tok_ready), .stk_in(stk_in), .stk_op(stk_op), .stk_apply(stk_apply),
    .stk_head(stk_head), .stk_empty(stk_empty), .stk_valid(stk_valid),
    .result(result), .result_valid(result_valid), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External stack with registered status; also tracks command traffic.
  always @(posedge clk) begin
    if (rst) begin
      stkCount  <= 0;
      stk_valid <= 1'b1;
      prevApply <= 1'b0;
    end else begin
      prevApply <= stk_apply;
      if (stk_apply) begin
        applyCount <= applyCount + 1;
        if (prevApply) backToBack <= backToBack + 1;
        if (stk_op == 4'd0) begin
          pushCount <= pushCount + 1;
          if (stkCount < Depth) begin
            stkMem[stkCount] <= stk_in;
            stkCount  <= stkCount + 1;
            stk_valid <= 1'b1;
          end else begin
            stk_valid <= 1'b0;
          end
        end else if (stk_op == 4'd1) begin
          if (stkCount > 0) begin
            stkCount  <= stkCount - 1;
            stk_valid <= 1'b1;
          end else begin
            stk_valid <= 1'b0;
          end
        end
      end
    end
  end

  assign stk_empty = (stkCount == 0);
  assign stk_head  = (stkCount > 0) ? stkMem[stkCount-1] : '0;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    if (observed != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Holds reset, checks every output is cleared, then checks tok_ready timing after release.
  task automatic resetAll();
    rst = 1'b1;
    tok_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", tok_ready, 0);
    checkOutput("rst_apply", stk_apply, 0);
    checkOutput("rst_stk_op", stk_op, 0);
    checkOutput("rst_stk_in", stk_in, 0);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_rv", result_valid, 0);
    checkOutput("rst_err", err, 0);
    model.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_early", tok_ready, 0);
    @(negedge clk);
    checkOutput("ready_after_rst", tok_ready, 1);
  endtask

  // Once in the error state: err stays set, nothing is accepted and the stack stays quiet.
  task automatic checkSticky();
    int applies0;
    applies0 = applyCount;
    repeat (3) @(negedge clk);
    tok_valid = 1'b1;
    tok_op = 2'd0;
    tok_num = 8'd1;
    repeat (3) @(negedge clk);
    tok_valid = 1'b0;
    checkOutput("err_sticky", err, 1);
    checkOutput("err_not_ready", tok_ready, 0);
    checkOutput("err_quiet", applyCount - applies0, 0);
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] num, output bit expectErr);
    int waitCycles, rvFirst, rvCount, readyAt, applies0, pushes0, ta, tb, r;
    logic [W-1:0] rvValue;
    waitCycles = 0;
    expectErr = 1'b0;
    r = 0;
    while (!tok_ready && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!tok_ready) begin
      checkOutput("ready_timeout", tok_ready, 1);
      expectErr = 1'b1;
      return;
    end
    applies0 = applyCount;
    pushes0 = pushCount;
    tok_valid = 1'b1;
    tok_op = op;
    tok_num = num;
    @(posedge clk);
    #1 tok_valid = 1'b0;

    if (op == 2'd0) begin
      if (model.size() >= Depth) expectErr = 1'b1;
      else model.push_back(int'(num));
    end else if (op == 2'd3 && !MulEn) begin
      expectErr = 1'b1;
    end else if (model.size() < 2) begin
      expectErr = 1'b1;
    end else begin
      ta = model.pop_back();
      tb = model.pop_back();
      case (op)
        2'd1:    r = (tb + ta) % 256;
        2'd2:    r = (tb - ta + 256) % 256;
        default: r = (tb * ta) % 256;
      endcase
      model.push_back(r);
    end

    rvFirst = 0;
    rvCount = 0;
    readyAt = 0;
    rvValue = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (result_valid) begin
        rvCount++;
        if (rvFirst == 0) begin
          rvFirst = c;
          rvValue = result;
        end
      end
      if (tok_ready && readyAt == 0) readyAt = c;
    end

    if (expectErr) begin
      checkOutput("err_set", err, 1);
      checkOutput("err_ready", tok_ready, 0);
      checkOutput("err_no_result", rvCount, 0);
      if (op != 2'd0) checkOutput("err_no_push", pushCount - pushes0, 0);
      if (op == 2'd3 && !MulEn) checkOutput("illegal_traffic", applyCount - applies0, 0);
    end else begin
      checkOutput("err_clear", err, 0);
      if (op == 2'd0) begin
        checkOutput("num_latency", readyAt, 3);
        checkOutput("num_no_result", rvCount, 0);
      end else begin
        checkOutput("op_latency", rvFirst, 7);
        checkOutput("rv_pulses", rvCount, 1);
        checkOutput("result", rvValue, r);
      end
      checkOutput("depth", stkCount, model.size());
      if (model.size() > 0) checkOutput("head", stk_head, model[$]);
    end
  endtask

  initial begin
    bit e;
    logic [1:0] op;
    rst = 1'b1;
    tok_valid = 1'b0;
    tok_op = 2'd0;
    tok_num = '0;
    applyCount = 0;
    pushCount = 0;
    backToBack = 0;

    resetAll();
    applyStimulus(2'd0, 8'd22, e);
    applyStimulus(2'd0, 8'd5, e);
    applyStimulus(2'd2, 8'd0, e);

    resetAll();
    applyStimulus(2'd0, 8'd200, e);
    applyStimulus(2'd0, 8'd100, e);
    applyStimulus(2'd1, 8'd0, e);

    resetAll();
    applyStimulus(2'd1, 8'd0, e);
    checkSticky();

    resetAll();
    for (int i = 0; i < Depth + 1; i++) applyStimulus(2'd0, 8'(i + 3), e);
    checkSticky();

    resetAll();
    applyStimulus(2'd0, 8'd12, e);
    applyStimulus(2'd0, 8'd11, e);
    applyStimulus(2'd3, 8'd0, e);
    if (e) checkSticky();

    resetAll();
    for (int i = 0; i < 250; i++) begin
      if (model.size() < 2 && $urandom_range(0, 9) != 0) op = 2'd0;
      else if ($urandom_range(0, 2) == 0) op = 2'd0;
      else op = 2'($urandom_range(1, 3));
      applyStimulus(op, 8'($urandom_range(0, 255)), e);
      if (e) begin
        checkSticky();
        resetAll();
      end
    end

    checkOutput("back_to_back", backToBack, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
